noc_credit_rx_deser: RTL and testbench

Single-clock receive endpoint for the credit-based flit link (data/dest/is_tail/send forward, credit back) that a router output port drives. It buffers incoming flits, returns one credit per flit consumed, and packs SERIALIZATION_FACTOR flits into one AXI-Stream beat. It sits at a router output that feeds a user core in the NoC clock domain, where no clock crossing is needed.

---
 rtl/noc_credit_rx_deser_if.sv | 35 +++
 rtl/noc_credit_rx_deser.sv | 231 +++++++++++++++++++++++
 tb/tb_noc_credit_rx_deser.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/noc_credit_rx_deser_if.sv
// Credit-based flit link plus AXI-Stream output bundle for noc_credit_rx_deser.
//   slave  : the receive endpoint (consumes flits, returns credits, drives AXIS)
//   master : the environment (router output port + AXIS sink)
// Signals:
//   data_in/dest_in/is_tail_in/send_in : flit forward path
//   credit_out                         : one pulse per freed buffer slot
//   axis_out_*                         : packed AXI-Stream beat
interface noc_credit_rx_deser_if #(
  parameter int FLIT_WIDTH           = 32,
  parameter int DEST_WIDTH           = 4,
  parameter int SERIALIZATION_FACTOR = 2
);
  localparam int TDATA_WIDTH = FLIT_WIDTH * SERIALIZATION_FACTOR;

  logic [FLIT_WIDTH-1:0]  data_in;
  logic [DEST_WIDTH-1:0]  dest_in;
  logic                   is_tail_in;
  logic                   send_in;
  logic                   credit_out;
  logic                   axis_out_tvalid;
  logic                   axis_out_tready;
  logic [TDATA_WIDTH-1:0] axis_out_tdata;
  logic                   axis_out_tlast;
  logic [DEST_WIDTH-1:0]  axis_out_tdest;

  modport slave (
    input  data_in, dest_in, is_tail_in, send_in, axis_out_tready,
    output credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tdest
  );

  modport master (
    output data_in, dest_in, is_tail_in, send_in, axis_out_tready,
    input  credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tdest
  );
endinterface

// File: rtl/noc_credit_rx_deser.sv
// Receive endpoint of a credit-based NoC flit link. Incoming flits are buffered
// in a small FIFO, one credit is returned per flit popped, and
// SERIALIZATION_FACTOR flits are packed into one AXI-Stream beat.
// Ports:
//   clk_noc      : NoC clock, rising edge
//   rst_n        : asynchronous active-low reset
//   lnk          : flit link in / credit out / AXIS out (slave modport)
//   overflow_err : sticky, a flit arrived with the FIFO full and no pop
//   dest_err     : sticky, a flit's dest differed from its packet's first dest
module noc_credit_rx_deser #(
  parameter int FLIT_WIDTH           = 32,
  parameter int DEST_WIDTH           = 4,
  parameter int SERIALIZATION_FACTOR = 2,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  noc_credit_rx_deser_if.slave   lnk,
  output logic                   overflow_err,
  output logic                   dest_err
);
  localparam int TDATA_WIDTH = FLIT_WIDTH * SERIALIZATION_FACTOR;
  localparam int ENTRY_W     = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int PTR_W       = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int CNT_W       = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int IDX_W       = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  // FIFO storage and pointers
  logic [ENTRY_W-1:0]    mem_r [FLIT_BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      cnt_r;

  // Assembler state and registered AXIS outputs
  state_t                state_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  tvalid_r;
  logic [TDATA_WIDTH-1:0] tdata_r;
  logic                  tlast_r;
  logic [DEST_WIDTH-1:0] tdest_r;

  // Packet dest tracking, credits and sticky errors
  logic [DEST_WIDTH-1:0] pkt_dest_r;
  logic                  pkt_open_r;
  logic                  credit_r;
  logic                  overflow_err_r;
  logic                  dest_err_r;

  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic                  pop_s;
  logic                  push_s;
  logic [ENTRY_W-1:0]    pop_entry_s;
  logic [FLIT_WIDTH-1:0] pop_data_s;
  logic [DEST_WIDTH-1:0] pop_dest_s;
  logic                  pop_tail_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FLIT_BUFFER_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign fifo_empty_s = (cnt_r == CNT_W'(0));
  assign fifo_full_s  = (cnt_r == CNT_W'(FLIT_BUFFER_DEPTH));
  assign pop_entry_s  = mem_r[rd_ptr_r];
  assign pop_data_s   = pop_entry_s[FLIT_WIDTH-1:0];
  assign pop_dest_s   = pop_entry_s[FLIT_WIDTH +: DEST_WIDTH];
  assign pop_tail_s   = pop_entry_s[ENTRY_W-1];

  // A full FIFO still accepts a flit when a slot frees in the same cycle.
  assign push_s = lnk.send_in && (!fifo_full_s || pop_s);

  // Pop decision: free-running in FILL, only alongside a handshake in VALID.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_FILL: pop_s = !fifo_empty_s;
      ST_VALID: begin
        if (lnk.axis_out_tready) begin
          pop_s = !fifo_empty_s;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO storage write (data path only, no reset needed).
  always_ff @(posedge clk_noc) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {lnk.is_tail_in, lnk.dest_in, lnk.data_in};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Beat assembler FSM with registered AXIS outputs.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_FILL;
      idx_r    <= '0;
      tvalid_r <= 1'b0;
      tdata_r  <= '0;
      tlast_r  <= 1'b0;
      tdest_r  <= '0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (pop_s) begin
            for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
              if (idx_r == IDX_W'(k)) begin
                tdata_r[k*FLIT_WIDTH +: FLIT_WIDTH] <= pop_data_s;
              end
            end
            if (idx_r == IDX_W'(0)) begin
              tdest_r <= pop_dest_s;
            end
            tlast_r <= tlast_r | pop_tail_s;
            // A tail closes the beat early; unused upper lanes stay zero.
            if ((idx_r == IDX_W'(SERIALIZATION_FACTOR - 1)) || pop_tail_s) begin
              state_r  <= ST_VALID;
              tvalid_r <= 1'b1;
              idx_r    <= '0;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        ST_VALID: begin
          if (lnk.axis_out_tready) begin
            if (pop_s) begin
              // Next beat starts in the same cycle the current one leaves.
              tdata_r <= TDATA_WIDTH'(pop_data_s);
              tdest_r <= pop_dest_s;
              tlast_r <= pop_tail_s;
              if ((SERIALIZATION_FACTOR == 1) || pop_tail_s) begin
                state_r  <= ST_VALID;
                tvalid_r <= 1'b1;
                idx_r    <= '0;
              end else begin
                state_r  <= ST_FILL;
                tvalid_r <= 1'b0;
                idx_r    <= IDX_W'(1);
              end
            end else begin
              state_r  <= ST_FILL;
              tvalid_r <= 1'b0;
              idx_r    <= '0;
              tdata_r  <= '0;
              tlast_r  <= 1'b0;
              tdest_r  <= '0;
            end
          end
        end
        default: begin
          state_r  <= ST_FILL;
          tvalid_r <= 1'b0;
          idx_r    <= '0;
          tdata_r  <= '0;
          tlast_r  <= 1'b0;
          tdest_r  <= '0;
        end
      endcase
    end
  end

  // Credit return, packet dest tracking and sticky error flags.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_r       <= 1'b0;
      pkt_dest_r     <= '0;
      pkt_open_r     <= 1'b0;
      overflow_err_r <= 1'b0;
      dest_err_r     <= 1'b0;
    end else begin
      credit_r <= pop_s;
      if (lnk.send_in && fifo_full_s && !pop_s) begin
        overflow_err_r <= 1'b1;
      end
      if (pop_s) begin
        if (!pkt_open_r) begin
          pkt_dest_r <= pop_dest_s;
          pkt_open_r <= !pop_tail_s;
        end else begin
          if (pop_dest_s != pkt_dest_r) begin
            dest_err_r <= 1'b1;
          end
          if (pop_tail_s) begin
            pkt_open_r <= 1'b0;
          end
        end
      end
    end
  end

  assign lnk.credit_out      = credit_r;
  assign lnk.axis_out_tvalid = tvalid_r;
  assign lnk.axis_out_tdata  = tdata_r;
  assign lnk.axis_out_tlast  = tlast_r;
  assign lnk.axis_out_tdest  = tdest_r;
  assign overflow_err        = overflow_err_r;
  assign dest_err            = dest_err_r;
endmodule

// File: tb/tb_noc_credit_rx_deser.sv
// Directed self-checking bench for noc_credit_rx_deser with default parameters.
module tb_noc_credit_rx_deser;
  logic clk_noc;
  logic rst_n;
  logic overflow_err;
  logic dest_err;

  int n_checks;
  int n_errors;

  noc_credit_rx_deser_if #(.FLIT_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(2)) bus ();

  noc_credit_rx_deser #(
    .FLIT_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(2), .FLIT_BUFFER_DEPTH(4)
  ) dut (
    .clk_noc      (clk_noc),
    .rst_n        (rst_n),
    .lnk          (bus.slave),
    .overflow_err (overflow_err),
    .dest_err     (dest_err)
  );

  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  // Monitor: credit pulses, longest credit run, accepted beats.
  int          cyc;
  int          credit_cnt;
  int          credit_run;
  int          credit_max_run;
  logic [63:0] q_data [$];
  logic [3:0]  q_dest [$];
  logic        q_last [$];
  int          q_cyc  [$];

  initial begin
    cyc = 0; credit_cnt = 0; credit_run = 0; credit_max_run = 0;
  end

  always @(posedge clk_noc) begin
    cyc = cyc + 1;
    if (bus.credit_out) begin
      credit_cnt = credit_cnt + 1;
      credit_run = credit_run + 1;
      if (credit_run > credit_max_run) credit_max_run = credit_run;
    end else begin
      credit_run = 0;
    end
    if (bus.axis_out_tvalid && bus.axis_out_tready) begin
      q_data.push_back(bus.axis_out_tdata);
      q_dest.push_back(bus.axis_out_tdest);
      q_last.push_back(bus.axis_out_tlast);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_flit(input logic [31:0] d, input logic [3:0] dst, input logic tail);
    bus.data_in    = d;
    bus.dest_in    = dst;
    bus.is_tail_in = tail;
    bus.send_in    = 1'b1;
    @(posedge clk_noc);
    #1;
    bus.send_in    = 1'b0;
    bus.is_tail_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_noc);
      #1;
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (q_data.size() < n && k < budget) begin
      @(posedge clk_noc);
      #1;
      k++;
    end
  endtask

  task automatic check_beat(input string tag, input logic [63:0] d, input logic [3:0] dst, input logic last);
    if (q_data.size() == 0) begin
      check_eq({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_tdata"}, q_data.pop_front(), d);
      check_eq({tag, "_tdest"}, 64'(q_dest.pop_front()), 64'(dst));
      check_eq({tag, "_tlast"}, 64'(q_last.pop_front()), 64'(last));
      void'(q_cyc.pop_front());
    end
  endtask

  initial begin
    int c0;
    logic [63:0] exp_d;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.data_in = 32'd0; bus.dest_in = 4'd0; bus.is_tail_in = 1'b0;
    bus.send_in = 1'b0; bus.axis_out_tready = 1'b0;
    repeat (3) @(posedge clk_noc);
    #1;
    check_eq("rst_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
    check_eq("rst_tdata", bus.axis_out_tdata, 64'd0);
    check_eq("rst_credit", 64'(bus.credit_out), 64'd0);
    check_eq("rst_errs", {62'd0, overflow_err, dest_err}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Two-flit packet -> one full beat, two credits.
    bus.axis_out_tready = 1'b1;
    c0 = credit_cnt;
    drive_flit(32'h11111111, 4'h5, 1'b0);
    drive_flit(32'h22222222, 4'h5, 1'b1);
    wait_beats(1, 20);
    idle(3);
    check_beat("basic", 64'h2222222211111111, 4'h5, 1'b1);
    check_eq("basic_credits", 64'(credit_cnt - c0), 64'd2);

    // Three-flit packet -> full beat then tail-closed half beat.
    c0 = credit_cnt;
    drive_flit(32'h0000000A, 4'h5, 1'b0);
    drive_flit(32'h0000000B, 4'h5, 1'b0);
    drive_flit(32'h0000000C, 4'h5, 1'b1);
    wait_beats(2, 20);
    idle(3);
    check_beat("three_b1", 64'h0000000B0000000A, 4'h5, 1'b0);
    check_beat("three_b2", 64'h000000000000000C, 4'h5, 1'b1);
    check_eq("three_credits", 64'(credit_cnt - c0), 64'd3);

    // Eight back-to-back flits -> continuous credits, beats every 2 cycles.
    q_cyc.delete();
    credit_max_run = 0;
    for (int i = 0; i < 8; i++) begin
      drive_flit(32'h00000100 + 32'(i), 4'h1, (i == 7));
    end
    wait_beats(4, 20);
    idle(3);
    check_eq("burst_credit_run", 64'(credit_max_run), 64'd8);
    check_eq("burst_nbeats", 64'(q_cyc.size()), 64'd4);
    if (q_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("burst_gap%0d", i), 64'(q_cyc[i+1] - q_cyc[i]), 64'd2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = {32'h00000100 + 32'(2*i+1), 32'h00000100 + 32'(2*i)};
      check_beat($sformatf("burst_b%0d", i), exp_d, 4'h1, (i == 3));
    end

    // Dest mismatch inside a packet: flagged, still delivered.
    check_eq("dest_err_clear", 64'(dest_err), 64'd0);
    drive_flit(32'h00000041, 4'h3, 1'b0);
    drive_flit(32'h00000042, 4'h7, 1'b1);
    wait_beats(1, 20);
    idle(2);
    check_beat("dest_beat", 64'h0000004200000041, 4'h3, 1'b1);
    check_eq("dest_err_set", 64'(dest_err), 64'd1);

    // Backpressure: 2 flits form a beat, 4 fill the FIFO, 7th overflows.
    bus.axis_out_tready = 1'b0;
    c0 = credit_cnt;
    check_eq("ovf_clear", 64'(overflow_err), 64'd0);
    for (int i = 0; i < 7; i++) begin
      drive_flit(32'h00000031 + 32'(i), 4'h6, (i == 5));
    end
    idle(3);
    check_eq("ovf_credits_held", 64'(credit_cnt - c0), 64'd2);
    check_eq("ovf_err", 64'(overflow_err), 64'd1);
    check_eq("ovf_tvalid", 64'(bus.axis_out_tvalid), 64'd1);
    bus.axis_out_tready = 1'b1;
    wait_beats(3, 30);
    idle(5);
    check_eq("ovf_nbeats", 64'(q_data.size()), 64'd3);
    check_beat("ovf_b0", 64'h0000003200000031, 4'h6, 1'b0);
    check_beat("ovf_b1", 64'h0000003400000033, 4'h6, 1'b0);
    check_beat("ovf_b2", 64'h0000003600000035, 4'h6, 1'b1);
    check_eq("ovf_credits_total", 64'(credit_cnt - c0), 64'd6);

    // Hold a valid beat under backpressure, then reset mid-beat.
    bus.axis_out_tready = 1'b0;
    drive_flit(32'hAAAA0001, 4'h9, 1'b0);
    drive_flit(32'hAAAA0002, 4'h9, 1'b1);
    begin
      int k;
      k = 0;
      while (!bus.axis_out_tvalid && k < 10) begin
        @(posedge clk_noc);
        #1;
        k++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_noc);
      #1;
      check_eq($sformatf("hold%0d_tvalid", i), 64'(bus.axis_out_tvalid), 64'd1);
      check_eq($sformatf("hold%0d_tdata", i), bus.axis_out_tdata, 64'hAAAA0002AAAA0001);
      check_eq($sformatf("hold%0d_tdest", i), 64'(bus.axis_out_tdest), 64'h9);
      check_eq($sformatf("hold%0d_tlast", i), 64'(bus.axis_out_tlast), 64'd1);
    end
    c0 = credit_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
    check_eq("arst_tdata", bus.axis_out_tdata, 64'd0);
    check_eq("arst_tdest_tlast", {59'd0, bus.axis_out_tdest, bus.axis_out_tlast}, 64'd0);
    check_eq("arst_errs", {62'd0, overflow_err, dest_err}, 64'd0);
    check_eq("arst_credit", 64'(bus.credit_out), 64'd0);
    idle(3);
    check_eq("arst_no_credits", 64'(credit_cnt - c0), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // After reset: no stale flits, single tail flit forms a half beat.
    bus.axis_out_tready = 1'b1;
    drive_flit(32'h00000055, 4'h2, 1'b1);
    wait_beats(1, 20);
    idle(5);
    check_eq("post_rst_nbeats", 64'(q_data.size()), 64'd1);
    check_beat("post_rst", 64'h0000000000000055, 4'h2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
